regfile_port_arbiter: RTL and testbench

- Shares the single read/write port set of the `processor` register file (two read addresses, one write) between two requesters, for example a fetch/decode stage and a load/store sequencer.
- Arbitration is round-robin with one grant per cycle.
- Each granted access is registered into a single stage that drives the register-file ports.
- The read data is then returned to the owning requester with a fixed latency.
- The block sits between the requesters and the register file, which has 32 x 64-bit registers, a synchronous write and asynchronous reads.

---
 rtl/proc_defs.sv | 14 +
 rtl/regfile_port_arbiter_rr_arbiter2.sv | 18 +
 rtl/regfile_port_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_port_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_defs.sv
// Shared definitions for the processor register-file access path.
package proc_defs;

    localparam int WORDSIZE_DEF = 64;
    localparam int SIZE_DEF     = 32;
    localparam int ADDRW_DEF    = $clog2(SIZE_DEF);
    localparam int NREQ         = 2;

    typedef logic [$clog2(NREQ)-1:0] req_id_t;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/regfile_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic; the priority pointer is held by the parent.
module rr_arbiter2
    import proc_defs::*;
(
    input  logic [1:0] valid,
    input  req_id_t    prio,
    output logic [1:0] grant
);

    // A lone requester always wins; on contention the pointer decides.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = (prio == req_id_t'(1)) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one register-file port set between two requesters with a
// single registered stage and a fixed two-cycle response latency.
module regfile_port_arbiter
    import proc_defs::*;
#(
    parameter  int WORDSIZE = WORDSIZE_DEF,
    parameter  int SIZE     = SIZE_DEF,
    localparam int ADDRW    = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_we,
    input  logic [2*ADDRW-1:0]    req_rs1,
    input  logic [2*ADDRW-1:0]    req_rs2,
    input  logic [2*ADDRW-1:0]    req_rd,
    input  logic [2*WORDSIZE-1:0] req_wdata,
    output logic [NREQ-1:0]       resp_valid,
    output logic [WORDSIZE-1:0]   resp_rs1,
    output logic [WORDSIZE-1:0]   resp_rs2,
    output logic [ADDRW-1:0]      rf_rs1,
    output logic [ADDRW-1:0]      rf_rs2,
    output logic [ADDRW-1:0]      rf_rd,
    output logic [WORDSIZE-1:0]   rf_rd_in,
    output logic                  rf_we,
    input  logic [WORDSIZE-1:0]   rf_rs1_out,
    input  logic [WORDSIZE-1:0]   rf_rs2_out
);

    logic [1:0]          grant;
    logic                xfer;
    req_id_t             prio;
    req_id_t             gid;

    logic                stg_valid;
    req_id_t             stg_id;
    logic                stg_we;
    logic [ADDRW-1:0]    stg_rs1;
    logic [ADDRW-1:0]    stg_rs2;
    logic [ADDRW-1:0]    stg_rd;
    logic [WORDSIZE-1:0] stg_wdata;

    rr_arbiter2 u_arb (
        .valid (req_valid),
        .prio  (prio),
        .grant (grant)
    );

    assign req_ready = grant;
    assign xfer      = |grant;
    assign gid       = req_id_t'(grant[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= '0;
        end else if (xfer) begin
            prio <= ~gid;
        end
    end

    // Addresses and data only load on a transfer so idle cycles keep the ports quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= 1'b0;
            stg_id    <= '0;
            stg_we    <= REQ_READ;
            stg_rs1   <= '0;
            stg_rs2   <= '0;
            stg_rd    <= '0;
            stg_wdata <= '0;
        end else begin
            stg_valid <= xfer;
            if (xfer) begin
                stg_id    <= gid;
                stg_we    <= req_we[gid];
                stg_rs1   <= req_rs1[gid*ADDRW +: ADDRW];
                stg_rs2   <= req_rs2[gid*ADDRW +: ADDRW];
                stg_rd    <= req_rd[gid*ADDRW +: ADDRW];
                stg_wdata <= req_wdata[gid*WORDSIZE +: WORDSIZE];
            end
        end
    end

    // rf_we is combinational from reset-cleared state, so it drops with rst_n at once.
    assign rf_rs1   = stg_rs1;
    assign rf_rs2   = stg_rs2;
    assign rf_rd    = stg_rd;
    assign rf_rd_in = stg_wdata;
    assign rf_we    = stg_valid & (stg_we == REQ_WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= '0;
            resp_rs1   <= '0;
            resp_rs2   <= '0;
        end else begin
            resp_valid <= stg_valid ? (2'b01 << stg_id) : 2'b00;
            if (stg_valid) begin
                resp_rs1 <= (stg_we == REQ_WRITE) ? '0 : rf_rs1_out;
                resp_rs2 <= (stg_we == REQ_WRITE) ? '0 : rf_rs2_out;
            end
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 32x64 register file.
module tb_regfile_port_arbiter;

    localparam int W = 64;
    localparam int A = 5;
    localparam logic [63:0] DATA_A = 64'h0000_0000_5f11_e01a;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [2*A-1:0]  req_rs1;
    logic [2*A-1:0]  req_rs2;
    logic [2*A-1:0]  req_rd;
    logic [2*W-1:0]  req_wdata;
    logic [1:0]      resp_valid;
    logic [W-1:0]    resp_rs1;
    logic [W-1:0]    resp_rs2;
    logic [A-1:0]    rf_rs1;
    logic [A-1:0]    rf_rs2;
    logic [A-1:0]    rf_rd;
    logic [W-1:0]    rf_rd_in;
    logic            rf_we;
    logic [W-1:0]    rf_rs1_out;
    logic [W-1:0]    rf_rs2_out;

    logic [W-1:0]    regs [32];

    int compared;
    int mismatched;

    regfile_port_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_rd     (req_rd),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rs1   (resp_rs1),
        .resp_rs2   (resp_rs2),
        .rf_rs1     (rf_rs1),
        .rf_rs2     (rf_rs2),
        .rf_rd      (rf_rd),
        .rf_rd_in   (rf_rd_in),
        .rf_we      (rf_we),
        .rf_rs1_out (rf_rs1_out),
        .rf_rs2_out (rf_rs2_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (rf_we) regs[rf_rd] <= rf_rd_in;
    end
    assign rf_rs1_out = regs[rf_rs1];
    assign rf_rs2_out = regs[rf_rs2];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic we, input logic [A-1:0] rs1,
                                 input logic [A-1:0] rs2, input logic [A-1:0] rd,
                                 input logic [W-1:0] wdata);
        req_valid[idx]        = 1'b1;
        req_we[idx]           = we;
        req_rs1[idx*A +: A]   = rs1;
        req_rs2[idx*A +: A]   = rs2;
        req_rd[idx*A +: A]    = rd;
        req_wdata[idx*W +: W] = wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = 2'b00;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_rd    = '0;
        req_wdata = '0;

        sample();
        checkOutput("reset_resp_valid", {62'd0, resp_valid}, 64'd0);
        checkOutput("reset_rf_we", {63'd0, rf_we}, 64'd0);
        checkOutput("reset_rf_rd", {59'd0, rf_rd}, 64'd0);
        checkOutput("reset_resp_rs1", resp_rs1, 64'd0);
        tick();
        rst_n = 1'b1;

        // Scenario 1 and 2: write x4 then read it back from the other requester.
        tick();
        applyStimulus(0, 1'b1, 5'd0, 5'd0, 5'd4, DATA_A);
        sample();
        checkOutput("s1_ready", {62'd0, req_ready}, 64'd1);
        tick();
        applyStimulus(1, 1'b0, 5'd4, 5'd0, 5'd0, 64'd0);
        sample();
        checkOutput("s1_rf_we", {63'd0, rf_we}, 64'd1);
        checkOutput("s1_rf_rd", {59'd0, rf_rd}, 64'd4);
        checkOutput("s1_rf_rd_in", rf_rd_in, DATA_A);
        checkOutput("s2_ready", {62'd0, req_ready}, 64'd2);
        tick();
        sample();
        checkOutput("s1_resp_valid", {62'd0, resp_valid}, 64'd1);
        checkOutput("s1_resp_rs1", resp_rs1, 64'd0);
        checkOutput("s2_rf_we", {63'd0, rf_we}, 64'd0);
        tick();
        sample();
        checkOutput("s2_resp_valid", {62'd0, resp_valid}, 64'd2);
        checkOutput("s2_resp_rs1", resp_rs1, DATA_A);
        checkOutput("s2_resp_rs2", resp_rs2, 64'd0);

        // Scenario 3: both requesters reading continuously alternate.
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k < 6) begin
                applyStimulus(0, 1'b0, 5'd4, 5'd0, 5'd0, 64'd0);
                applyStimulus(1, 1'b0, 5'd0, 5'd4, 5'd0, 64'd0);
            end
            sample();
            checkOutput($sformatf("s3_ready_%0d", k), {62'd0, req_ready},
                        (k >= 6) ? 64'd0 : ((k % 2) ? 64'd2 : 64'd1));
            if (k >= 2) begin
                checkOutput($sformatf("s3_resp_valid_%0d", k), {62'd0, resp_valid},
                            (k % 2) ? 64'd2 : 64'd1);
                checkOutput($sformatf("s3_resp_rs1_%0d", k), resp_rs1,
                            (k % 2) ? 64'd0 : DATA_A);
            end
        end

        // Scenario 4: two writes to x7 back to back, then a read sees the later one.
        tick();
        applyStimulus(0, 1'b1, 5'd0, 5'd0, 5'd7, 64'h1);
        sample();
        checkOutput("s4_ready_w0", {62'd0, req_ready}, 64'd1);
        tick();
        applyStimulus(1, 1'b1, 5'd0, 5'd0, 5'd7, 64'h2);
        sample();
        checkOutput("s4_ready_w1", {62'd0, req_ready}, 64'd2);
        tick();
        applyStimulus(0, 1'b0, 5'd7, 5'd4, 5'd0, 64'd0);
        sample();
        checkOutput("s4_ready_rd", {62'd0, req_ready}, 64'd1);
        tick();
        sample();
        checkOutput("s4_resp_w1_valid", {62'd0, resp_valid}, 64'd2);
        checkOutput("s4_resp_w1_rs1", resp_rs1, 64'd0);
        tick();
        sample();
        checkOutput("s4_resp_rd_valid", {62'd0, resp_valid}, 64'd1);
        checkOutput("s4_resp_rd_rs1", resp_rs1, 64'h2);
        checkOutput("s4_resp_rd_rs2", resp_rs2, DATA_A);

        // Scenario 5: asynchronous reset while a write to x9 sits in the stage.
        tick();
        applyStimulus(0, 1'b1, 5'd0, 5'd0, 5'd9, 64'hdead_beef);
        sample();
        checkOutput("s5_ready", {62'd0, req_ready}, 64'd1);
        tick();
        #1;
        checkOutput("s5_rf_we_before", {63'd0, rf_we}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("s5_rf_we_after", {63'd0, rf_we}, 64'd0);
        checkOutput("s5_resp_valid_rst", {62'd0, resp_valid}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample();
            checkOutput($sformatf("s5_no_resp_%0d", k), {62'd0, resp_valid}, 64'd0);
            tick();
        end
        checkOutput("s5_x9_unchanged", regs[9], 64'd0);
        applyStimulus(0, 1'b0, 5'd7, 5'd4, 5'd0, 64'd0);
        applyStimulus(1, 1'b0, 5'd4, 5'd7, 5'd0, 64'd0);
        sample();
        checkOutput("s5_prio_reset", {62'd0, req_ready}, 64'd1);
        tick();
        sample();
        tick();
        sample();
        checkOutput("s5_post_resp_valid", {62'd0, resp_valid}, 64'd1);
        checkOutput("s5_post_resp_rs1", resp_rs1, 64'h2);

        // Scenario 6: idle cycles keep everything quiet and hold response data.
        for (int k = 0; k < 5; k++) begin
            tick();
            sample();
            checkOutput($sformatf("s6_ready_%0d", k), {62'd0, req_ready}, 64'd0);
            checkOutput($sformatf("s6_rf_we_%0d", k), {63'd0, rf_we}, 64'd0);
            checkOutput($sformatf("s6_resp_valid_%0d", k), {62'd0, resp_valid}, 64'd0);
            checkOutput($sformatf("s6_resp_rs1_%0d", k), resp_rs1, 64'h2);
            checkOutput($sformatf("s6_resp_rs2_%0d", k), resp_rs2, DATA_A);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
